// File: rtl/ubm_replay_buffer_pkg.sv
// Shared flit width and 2-bit flit type encodings for the UBM replay buffer.
// Flit type sits in the two MSBs of every flit.
package ubm_replay_buffer_pkg;
    localparam int         FLIT_WIDTH = 32;
    localparam logic [1:0] FT_HEAD    = 2'b00;
    localparam logic [1:0] FT_BODY    = 2'b01;
    localparam logic [1:0] FT_TAIL    = 2'b10;
    localparam logic [1:0] FT_SINGLE  = 2'b11;
endpackage

// File: rtl/ubm_buf_mem.sv
// DEPTH x FLIT_W register array: one synchronous write port, one combinational read port.
// Write data is readable from the cycle after the write edge; no backpressure.
module ubm_buf_mem #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 16,
    parameter int PW     = 4
)(
    input  logic              clk,
    input  logic              i_we,
    input  logic [PW-1:0]     i_waddr,
    input  logic [FLIT_W-1:0] i_wdat,
    input  logic [PW-1:0]     i_raddr,
    output logic [FLIT_W-1:0] o_rdat
);
    logic [FLIT_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];
endmodule

// File: rtl/ubm_replay_buffer.sv
// Per-port flit buffer with replay: packets are re-read per destination, freed only on pop.
// FWFT read, 1-cycle write-to-visible and commit-to-credit; upstream is credit-controlled, overflow writes are dropped.
module ubm_replay_buffer
    import ubm_replay_buffer_pkg::*;
#(
    parameter int FLIT_W = FLIT_WIDTH,
    parameter int DEPTH  = 16
)(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    input  logic [FLIT_W-1:0]     in_flit,
    output logic                  credit_out,
    output logic                  fifo_empty,
    output logic [FLIT_W-1:0]     out_flit,
    output logic [1:0]            flit_type,
    input  logic                  flit_fire,
    input  logic                  pop,
    input  logic                  read_reset,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                  overflow_err,
    output logic                  underflow_err
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0] r_wr_ptr;
    logic [PW:0] r_rd_ptr;
    logic [PW:0] r_cm_ptr;
    logic        r_credit;
    logic        r_overflow;
    logic        r_underflow;

    logic [PW:0] w_occ;
    logic [PW:0] w_rd_dist;
    logic        w_full;
    logic        w_empty;
    logic        w_wr_en;
    logic        w_fire;
    logic        w_commit;
    logic [PW:0] w_cm_ptr_nxt;
    logic [PW:0] w_rd_ptr_nxt;

    assign w_occ     = r_wr_ptr - r_cm_ptr;
    assign w_rd_dist = r_rd_ptr - r_cm_ptr;
    assign w_full    = (w_occ == (PW+1)'(DEPTH));
    assign w_empty   = (r_rd_ptr == r_wr_ptr);
    // Full is judged before this cycle's commit frees an entry.
    assign w_wr_en   = in_valid & ~w_full;
    assign w_fire    = flit_fire & ~w_empty;
    assign w_commit  = w_fire & pop;

    assign w_cm_ptr_nxt = r_cm_ptr + (PW+1)'(w_commit);
    // Rewind lands on the post-commit head, so a committing tail never replays.
    assign w_rd_ptr_nxt = read_reset ? w_cm_ptr_nxt : (r_rd_ptr + (PW+1)'(w_fire));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cm_ptr    <= '0;
            r_credit    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_cm_ptr    <= w_cm_ptr_nxt;
            r_credit    <= w_commit;
            r_overflow  <= r_overflow | (in_valid & w_full);
            r_underflow <= r_underflow | (flit_fire & w_empty);
        end
    end

    ubm_buf_mem #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH),
        .PW     (PW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr[PW-1:0]),
        .i_wdat  (in_flit),
        .i_raddr (r_rd_ptr[PW-1:0]),
        .o_rdat  (out_flit)
    );

    assign flit_type     = out_flit[FLIT_W-1 -: 2];
    assign fifo_empty    = w_empty;
    assign occupancy     = w_occ;
    assign credit_out    = r_credit;
    assign overflow_err  = r_overflow;
    assign underflow_err = r_underflow;

    // Read pointer must stay between commit and write pointers.
    a_ptr_order: assert property (@(posedge clk) disable iff (!rstn) (w_rd_dist <= w_occ));
endmodule

// File: doc/ubm_replay_buffer.md
Name: ubm_replay_buffer

Overview:
- Per-input-port flit buffer that directly feeds the cast input controller.
- Supports unicast-based multicast (UBM) replay: a packet is read out once per destination and freed only on the final pass, when the controller asserts pop.
- Three pointers:
  - write pointer
  - speculative read pointer
  - commit (head) pointer
- Returns one credit upstream per committed (freed) entry.

Parameters:
- FLIT_W, `FLIT_WIDTH, total flit width; flit_type is bits [FLIT_W-1:FLIT_W-2].
- DEPTH, 16, entry count; must be a power of two and at least 2.
- PW, $clog2(DEPTH), pointer index width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- in_valid  in  1  upstream flit write strobe; upstream is credit-controlled.
- in_flit  in  FLIT_W  upstream flit.
- credit_out  out  1  one-cycle pulse per freed entry, to upstream credit counter.
- fifo_empty  out  1  no unread flit at the read pointer.
- out_flit  out  FLIT_W  flit at the read pointer (first-word fall-through).
- flit_type  out  2  out_flit[FLIT_W-1:FLIT_W-2].
- flit_fire  in  1  current out_flit consumed by the crossbar.
- pop  in  1  commit the flit fired this cycle.
- read_reset  in  1  rewind the read pointer to the commit pointer.
- occupancy  out  PW+1  committed-pointer-to-write-pointer entry count.
- overflow_err  out  1  sticky: write attempted while full.
- underflow_err  out  1  sticky: flit_fire while fifo_empty.

Behaviour:
- All state is clk-synchronous. rstn low at any posedge clears, on the next edge:
  - wr_ptr, rd_ptr, cm_ptr to 0;
  - credit_out, overflow_err, underflow_err to 0.
- After reset: fifo_empty=1, occupancy=0. Memory contents are not reset.
- Reset mid-packet discards all buffered flits and any replay state.
- Pointers are PW+1 bits; the MSB is a wrap bit.
  - full = (wr_ptr - cm_ptr) == DEPTH.
  - fifo_empty = (rd_ptr == wr_ptr).
  - occupancy = wr_ptr - cm_ptr, modulo 2^(PW+1).
- Write:
  - in_valid & ~full: mem[wr_ptr[PW-1:0]] <= in_flit; wr_ptr+1.
  - in_valid & full: write dropped, overflow_err <= 1.
  - A written flit is visible at out_flit, and fifo_empty deasserts, the cycle after the write (no write-to-read bypass).
- Read:
  - out_flit = mem[rd_ptr[PW-1:0]], combinational; undefined while fifo_empty.
  - fire_v = flit_fire & ~fifo_empty.
  - flit_fire & fifo_empty: ignored, underflow_err <= 1.
- Commit:
  - commit = fire_v & pop; then cm_ptr <= cm_ptr + 1.
  - pop without a valid fire is ignored.
- Rewind:
  - rd_ptr_next = read_reset ? cm_ptr_next : rd_ptr + fire_v.
  - read_reset has priority over the fire increment.
  - read_reset & fire_v & pop on the same cycle gives rd_ptr = cm_ptr + 1, a consistent outcome.
- Invariant: cm_ptr <= rd_ptr <= wr_ptr (modulo arithmetic). An RTL assertion flags any violation.
- Credit:
  - credit_out <= commit, registered, so the pulse arrives 1 cycle after the committing edge.
  - Exactly one pulse per freed entry. Total pulses equal total commits.
- Non-UBM flow: the controller drives pop=1 constantly, so each fire commits immediately and the block behaves as a plain FIFO.
- UBM flow:
  - A multicast packet is fired with pop=0 on each non-final pass; read_reset pulses with the tail fire, and the next read is the head again.
  - On the final pass pop=1 commits each flit as fired.
- Simultaneous write and commit while full: the write is dropped, because full is evaluated before the commit frees space. Credit protocol prevents this case.
- Latency:
  - write to fifo_empty low: 1 cycle;
  - fire to next flit visible: 1 cycle;
  - commit to credit_out: 1 cycle.

Decomposition:
- Shared package / params.svh holds `FLIT_WIDTH and the `HEAD/`BODY/`TAIL/`SINGLE 2-bit flit type encodings. No new typedefs.
- One natural sub-module: ubm_buf_mem, a DEPTH x FLIT_W register array with 1 synchronous write port and 1 combinational read port. Pointer, commit and credit logic stays in the top.

Test Plan:
- Plain FIFO: pop=1. Write HEAD,BODY,BODY,TAIL (4 flits), fire one per cycle.
  - Required: out order identical; 4 credit_out pulses, each 1 cycle after its fire; occupancy returns to 0; fifo_empty=1.
- UBM two-pass: write a 3-flit packet. Fire it with pop=0, read_reset on the tail fire, then fire it again with pop=1.
  - Required: HEAD reappears on the cycle after read_reset; occupancy stays 3 through pass 1; exactly 3 credit pulses, all during pass 2.
- Full boundary, DEPTH=16: write 16 flits with no fire, then in_valid=1 on cycle 17.
  - Required: occupancy=16, overflow_err=1, flit 17 absent.
  - Then one commit: the next write is accepted.
- Wrap-around: 40 single-flit packets streamed with write and fire concurrent.
  - Required: data intact across pointer wrap; credits=40.
- Simultaneous read_reset & fire & pop on a TAIL.
  - Required: rd_ptr = cm_ptr = old cm_ptr + 1; no replay; 1 credit.
- Reset mid-replay: rstn=0 for 1 cycle after 2 flits of pass 1.
  - Required: fifo_empty=1, occupancy=0, no credit_out, errors cleared.
- Underflow: flit_fire=1 while fifo_empty.
  - Required: pointers unchanged, underflow_err=1.
